databus_arbiter: RTL and testbench

- Shares one memory-side DataBus slave between two bus masters: port 0 is CPU instruction fetch and port 1 is the CPU load/store unit or DMA.
- Masters place requests using the existing DataBus semantics: read/write strobes, address, data, and `ready` handshake.
- Arbitration is round-robin with a registered grant. A bus-timeout watchdog reports an error to a master whose slave never responds.
- Sits between CPUCore master ports and the memory model / memory controller.

---
 rtl/databus_arbiter.sv | 150 +++++++++++++++
 tb/tb_databus_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/databus_arbiter.sv
// databus_arbiter
// Two-master round-robin arbiter in front of a single DataBus slave.
// Port 0 is instruction fetch, port 1 is load/store or DMA. The grant is
// registered, so every transfer costs at least one arbitration cycle plus
// one slave cycle. A watchdog aborts transfers the slave never finishes.
//
// TIMEOUT must be >= 1 and 2**TW must exceed TIMEOUT.

module databus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15,
  parameter int TW      = 4
) (
  input  logic          clk,
  input  logic          res,
  // master 0
  input  logic          m0_read,
  input  logic          m0_write,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ready,
  output logic          m0_err,
  // master 1
  input  logic          m1_read,
  input  logic          m1_write,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ready,
  output logic          m1_err,
  // slave side
  output logic          s_read,
  output logic          s_write,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_ready,
  // current owner, one-hot; zero while idle
  output logic [1:0]    grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

  state_t        state;
  logic          last;   // index of the port served most recently
  logic [TW-1:0] tcnt;   // BUSY cycles spent without s_ready

  logic req0;
  logic req1;
  logic own_req;
  logic done;
  logic expire;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Request of the current owner; a dropped request ends the transfer quietly.
  assign own_req = (state == BUSY0) ? req0 :
                   (state == BUSY1) ? req1 : 1'b0;

  // Completion wins over the watchdog when both land on the same cycle.
  assign done   = own_req & s_ready;
  assign expire = own_req & ~s_ready & (tcnt == TW'(TIMEOUT - 1));

  // Slave-side mux and per-master response pulses for the current owner.
  // NOTE: every output gets a default first so no path through the case leaves one unassigned (no latch).
  always_comb begin
    s_read   = 1'b0;
    s_write  = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    m0_ready = 1'b0;
    m0_err   = 1'b0;
    m0_rdata = '0;
    m1_ready = 1'b0;
    m1_err   = 1'b0;
    m1_rdata = '0;
    case (state)
      BUSY0: begin
        s_write  = m0_write;
        s_read   = m0_read & ~m0_write;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        m0_ready = done;
        m0_err   = expire;
        m0_rdata = done ? s_rdata : '0;
      end
      BUSY1: begin
        s_write  = m1_write;
        s_read   = m1_read & ~m1_write;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        m1_ready = done;
        m1_err   = expire;
        m1_rdata = done ? s_rdata : '0;
      end
      default: ;
    endcase
  end

  // Arbitration FSM with registered grant, fairness pointer and watchdog.
  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state <= IDLE;
      last  <= 1'b1;
      tcnt  <= '0;
      grant <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (req0 && (!req1 || last)) begin
            state <= BUSY0;
            grant <= 2'b01;
          end else if (req1) begin
            state <= BUSY1;
            grant <= 2'b10;
          end
        end
        BUSY0, BUSY1: begin
          if (!own_req) begin
            state <= IDLE;
            grant <= 2'b00;
            tcnt  <= '0;
          end else if (s_ready || expire) begin
            state <= IDLE;
            grant <= 2'b00;
            tcnt  <= '0;
            last  <= (state == BUSY1);
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
          tcnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_databus_arbiter.sv
// Bench for databus_arbiter: scenario tasks with inline checks, plus a
// scoreboard of expected ready/err responses consumed by a monitor.

module tb_databus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          res;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          m0_ready, m1_ready, m0_err, m1_err;
  logic          s_read, s_write;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [DW-1:0] s_rdata;
  logic          s_ready;
  logic [1:0]    grant;

  // slave model: either zero-wait (answers whatever is strobed) or manual
  logic          slave_auto;
  logic          s_ready_m;
  logic [DW-1:0] s_rdata_m;
  assign s_ready = slave_auto ? (s_read | s_write) : s_ready_m;
  assign s_rdata = slave_auto ? (32'h0000_1000 | s_addr) : s_rdata_m;

  typedef struct {
    int          port;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  databus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(15), .TW(4)) dut (
    .clk      (clk),
    .res      (res),
    .m0_read  (m0_read),
    .m0_write (m0_write),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_rdata (m0_rdata),
    .m0_ready (m0_ready),
    .m0_err   (m0_err),
    .m1_read  (m1_read),
    .m1_write (m1_write),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_rdata (m1_rdata),
    .m1_ready (m1_ready),
    .m1_err   (m1_err),
    .s_read   (s_read),
    .s_write  (s_write),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_rdata  (s_rdata),
    .s_ready  (s_ready),
    .grant    (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every ready/err pulse must match the next scoreboard entry,
  // idle ports must show zero rdata, and grant must be one-hot or zero.
  always @(negedge clk) begin
    if (!res) begin
      for (int p = 0; p < 2; p++) begin
        logic        r;
        logic        e;
        logic [31:0] d;
        exp_t        x;
        r = (p == 0) ? m0_ready : m1_ready;
        e = (p == 0) ? m0_err   : m1_err;
        d = (p == 0) ? m0_rdata : m1_rdata;
        checks++;
        if (r === 1'b1 && e === 1'b1) begin
          errors++;
          $display("FAIL ready_err_both port%0d: ready=1 err=1, required at most one", p);
        end
        if (r === 1'b1 || e === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp port%0d: ready=%b err=%b rdata=%h, required no response", p, r, e, d);
          end else begin
            x = exp_q.pop_front();
            if (x.port != p || x.err != e || (!x.err && d !== x.rdata)) begin
              errors++;
              $display("FAIL scoreboard port%0d: got err=%b rdata=%h, required port%0d err=%b rdata=%h",
                       p, e, d, x.port, x.err, x.rdata);
            end
          end
        end else begin
          checks++;
          if (d !== 32'h0) begin
            errors++;
            $display("FAIL idle_rdata port%0d: rdata=%h, required 0", p, d);
          end
        end
      end
      checks++;
      if (!(grant === 2'b00 || grant === 2'b01 || grant === 2'b10)) begin
        errors++;
        $display("FAIL grant_onehot: grant=%b, required 00/01/10", grant);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_read = 0; m0_write = 0; m0_addr = '0; m0_wdata = '0;
    m1_read = 0; m1_write = 0; m1_addr = '0; m1_wdata = '0;
    slave_auto = 0; s_ready_m = 0; s_rdata_m = '0;
  endtask

  task automatic do_reset();
    res = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 res = 1'b0;
  endtask

  task automatic chk_grant(input string name, input logic [1:0] req);
    checks++;
    if (grant !== req) begin
      errors++;
      $display("FAIL %s: grant=%b, required %b", name, grant, req);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic chk_word(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic chk_all_zero(input string name);
    checks++;
    if ({grant, s_read, s_write, m0_ready, m1_ready, m0_err, m1_err} !== 8'b0 ||
        s_addr !== '0 || s_wdata !== '0 || m0_rdata !== '0 || m1_rdata !== '0) begin
      errors++;
      $display("FAIL %s: grant=%b s_read=%b s_write=%b rdy=%b%b err=%b%b s_addr=%h, required all 0",
               name, grant, s_read, s_write, m1_ready, m0_ready, m1_err, m0_err, s_addr);
    end
  endtask

  task automatic test_reset();
    res = 1'b1;
    clear_inputs();
    m0_read = 1; m1_write = 1; m0_addr = 32'h10; m1_addr = 32'h20;
    #1;
    chk_all_zero("reset_outputs");
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset_held");
    do_reset();
    @(negedge clk);
    chk_all_zero("after_release");
  endtask

  task automatic test_single_read();
    do_reset();
    m0_read = 1; m0_addr = 32'h40;
    exp_q.push_back('{port: 0, err: 1'b0, rdata: 32'h4});
    @(negedge clk);
    chk_grant("single_arb_latency", 2'b00);
    step();
    s_rdata_m = 32'h4; s_ready_m = 1;
    @(negedge clk);
    chk_grant("single_grant", 2'b01);
    chk_bit("single_s_read", s_read, 1'b1);
    chk_word("single_s_addr", s_addr, 32'h40);
    chk_bit("single_m0_ready", m0_ready, 1'b1);
    chk_word("single_m0_rdata", m0_rdata, 32'h4);
    step();
    m0_read = 0; s_ready_m = 0;
    @(negedge clk);
    chk_grant("single_back_idle", 2'b00);
  endtask

  task automatic test_round_robin();
    logic [1:0] seq [6];
    seq = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    do_reset();
    slave_auto = 1;
    m0_read = 1;  m0_addr = 32'h0;
    m1_write = 1; m1_addr = 32'h4C; m1_wdata = 32'h9;
    exp_q.push_back('{port: 0, err: 1'b0, rdata: 32'h1000});
    exp_q.push_back('{port: 1, err: 1'b0, rdata: 32'h104C});
    exp_q.push_back('{port: 0, err: 1'b0, rdata: 32'h1000});
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk_grant($sformatf("rr_seq%0d", i), seq[i]);
      if (i == 3) begin
        chk_bit("rr_s_write", s_write, 1'b1);
        chk_bit("rr_s_read", s_read, 1'b0);
        chk_word("rr_s_wdata", s_wdata, 32'h9);
        chk_word("rr_s_addr", s_addr, 32'h4C);
      end
      if (i < 5) step();
    end
    step();
    m0_read = 0; m1_write = 0; slave_auto = 0;
    @(negedge clk);
    chk_grant("rr_idle", 2'b00);
  endtask

  task automatic test_wait_states();
    m1_read = 1; m1_addr = 32'h80; s_rdata_m = 32'h1234_5678;
    exp_q.push_back('{port: 1, err: 1'b0, rdata: 32'hDEAD_BEEF});
    step();
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin
        s_ready_m = 1; s_rdata_m = 32'hDEAD_BEEF;
      end
      m0_addr = 32'hF00 + 32'(c);
      @(negedge clk);
      chk_grant($sformatf("wait_grant_c%0d", c), 2'b10);
      chk_word($sformatf("wait_s_addr_c%0d", c), s_addr, 32'h80);
      chk_bit($sformatf("wait_m1_ready_c%0d", c), m1_ready, (c == 3) ? 1'b1 : 1'b0);
      chk_bit($sformatf("wait_m1_err_c%0d", c), m1_err, 1'b0);
      chk_bit($sformatf("wait_m0_ready_c%0d", c), m0_ready, 1'b0);
      chk_bit($sformatf("wait_m0_err_c%0d", c), m0_err, 1'b0);
      chk_word($sformatf("wait_m1_rdata_c%0d", c), m1_rdata, (c == 3) ? 32'hDEAD_BEEF : 32'h0);
      step();
    end
    m1_read = 0; s_ready_m = 0;
    @(negedge clk);
    chk_grant("wait_idle", 2'b00);
  endtask

  task automatic test_timeout();
    do_reset();
    m0_read = 1; m0_addr = 32'h100;
    m1_read = 1; m1_addr = 32'h200;
    exp_q.push_back('{port: 0, err: 1'b1, rdata: 32'h0});
    step();
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      chk_grant($sformatf("to_grant_c%0d", c), 2'b01);
      chk_bit($sformatf("to_m0_err_c%0d", c), m0_err, (c == 15) ? 1'b1 : 1'b0);
      chk_bit($sformatf("to_m0_ready_c%0d", c), m0_ready, 1'b0);
      if (c < 15) step();
    end
    step();
    @(negedge clk);
    chk_grant("to_back_idle", 2'b00);
    exp_q.push_back('{port: 1, err: 1'b0, rdata: 32'h1200});
    slave_auto = 1;
    step();
    m0_read = 0;
    @(negedge clk);
    chk_grant("to_m1_next", 2'b10);
    chk_bit("to_m1_ready", m1_ready, 1'b1);
    step();
    m1_read = 0; slave_auto = 0;
    @(negedge clk);
    chk_grant("to_m1_idle", 2'b00);

    // s_ready on the last permitted cycle completes instead of aborting
    m0_read = 1; m0_addr = 32'h104;
    exp_q.push_back('{port: 0, err: 1'b0, rdata: 32'h55AA});
    step();
    for (int c = 1; c <= 15; c++) begin
      if (c == 15) begin
        s_ready_m = 1; s_rdata_m = 32'h55AA;
      end
      @(negedge clk);
      chk_grant($sformatf("tr_grant_c%0d", c), 2'b01);
      chk_bit($sformatf("tr_m0_err_c%0d", c), m0_err, 1'b0);
      chk_bit($sformatf("tr_m0_ready_c%0d", c), m0_ready, (c == 15) ? 1'b1 : 1'b0);
      step();
    end
    m0_read = 0; s_ready_m = 0;
    @(negedge clk);
    chk_grant("tr_idle", 2'b00);
  endtask

  task automatic test_read_write();
    m0_read = 1; m0_write = 1; m0_addr = 32'h30; m0_wdata = 32'h5;
    exp_q.push_back('{port: 0, err: 1'b0, rdata: 32'h77});
    step();
    s_ready_m = 1; s_rdata_m = 32'h77;
    @(negedge clk);
    chk_grant("rw_grant", 2'b01);
    chk_bit("rw_s_write", s_write, 1'b1);
    chk_bit("rw_s_read", s_read, 1'b0);
    chk_word("rw_s_wdata", s_wdata, 32'h5);
    chk_word("rw_s_addr", s_addr, 32'h30);
    step();
    m0_read = 0; m0_write = 0; s_ready_m = 0;
    @(negedge clk);
    chk_grant("rw_idle", 2'b00);
  endtask

  task automatic test_drop();
    do_reset();
    m0_read = 1; m0_addr = 32'h20;
    step();
    @(negedge clk);
    chk_grant("drop_grant", 2'b01);
    step();
    m0_read = 0;
    @(negedge clk);
    chk_grant("drop_still_owner", 2'b01);
    chk_bit("drop_s_read", s_read, 1'b0);
    chk_bit("drop_m0_ready", m0_ready, 1'b0);
    chk_bit("drop_m0_err", m0_err, 1'b0);
    step();
    @(negedge clk);
    chk_grant("drop_idle", 2'b00);
    // fairness pointer untouched: port 0 still wins the tie
    m0_read = 1; m1_read = 1; m1_addr = 32'h60; slave_auto = 1;
    exp_q.push_back('{port: 0, err: 1'b0, rdata: 32'h1020});
    step();
    @(negedge clk);
    chk_grant("drop_tie_port0", 2'b01);
    step();
    m0_read = 0; m1_read = 0; slave_auto = 0;
    @(negedge clk);
    chk_grant("drop_tie_idle", 2'b00);
  endtask

  task automatic test_reset_mid();
    m1_read = 1; m1_addr = 32'h300;
    step();
    @(negedge clk);
    chk_grant("rst_mid_busy1", 2'b10);
    chk_bit("rst_mid_s_read", s_read, 1'b1);
    #2;
    res = 1'b1;
    m0_read = 1; m0_addr = 32'h40;
    #1;
    chk_all_zero("rst_mid_async");
    step();
    step();
    res = 1'b0;
    slave_auto = 1;
    exp_q.push_back('{port: 0, err: 1'b0, rdata: 32'h1040});
    @(negedge clk);
    chk_grant("rst_mid_release", 2'b00);
    step();
    @(negedge clk);
    chk_grant("rst_mid_port0_first", 2'b01);
    chk_bit("rst_mid_m0_ready", m0_ready, 1'b1);
    step();
    m0_read = 0; m1_read = 0; slave_auto = 0;
    @(negedge clk);
    chk_grant("rst_mid_idle", 2'b00);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_wait_states();
    test_timeout();
    test_read_write();
    test_drop();
    test_reset_mid();
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
